// File: rtl/fm0_viterbi_pkg.sv
// Shared encodings for the FM0 soft-decision Viterbi decoder: symbol/state
// indices, trellis predecessor table, per-state data bit and FSM states.
package fm0_viterbi_pkg;

    localparam logic [1:0] S0 = 2'd0;  // (+,+) data 1
    localparam logic [1:0] S1 = 2'd1;  // (+,-) data 0
    localparam logic [1:0] S2 = 2'd2;  // (-,+) data 0
    localparam logic [1:0] S3 = 2'd3;  // (-,-) data 1

    // A symbol must start at the inverse of the previous end level, so states
    // starting high follow {S1,S3} and states starting low follow {S0,S2}.
    localparam logic [3:0][1:0] PRED_LO = {S0, S0, S1, S1};
    localparam logic [3:0][1:0] PRED_HI = {S2, S2, S3, S3};

    localparam logic [3:0] STATE_BIT = 4'b1001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/fm0_acs_norm.sv
// Combinational four-state add-compare-select with max search and
// saturating normalisation so the surviving best metric is always zero.
module fm0_acs_norm
    import fm0_viterbi_pkg::*;
#(
    parameter int CORR_WIDTH   = 8,
    parameter int METRIC_WIDTH = CORR_WIDTH + 3
) (
    input  logic [4*CORR_WIDTH-1:0]        corr,
    input  logic [3:0][METRIC_WIDTH-1:0]   metric,
    output logic [3:0][METRIC_WIDTH-1:0]   metric_new,
    output logic [3:0]                     dec,
    output logic [1:0]                     best
);

    localparam int SW = METRIC_WIDTH + 1;
    localparam logic signed [SW-1:0] SAT_MIN = {2'b11, {(METRIC_WIDTH-1){1'b0}}};

    logic signed [SW-1:0] sel [4];
    logic signed [SW-1:0] max_val;

    for (genvar s = 0; s < 4; s++) begin : g_acs
        logic [CORR_WIDTH-1:0]   c;
        logic [METRIC_WIDTH-1:0] m_lo;
        logic [METRIC_WIDTH-1:0] m_hi;
        logic signed [SW-1:0]    corr_ext;
        logic signed [SW-1:0]    cand_lo;
        logic signed [SW-1:0]    cand_hi;
        logic signed [SW-1:0]    diff;

        assign c        = corr[s*CORR_WIDTH +: CORR_WIDTH];
        assign m_lo     = metric[PRED_LO[s]];
        assign m_hi     = metric[PRED_HI[s]];
        assign corr_ext = {{(SW-CORR_WIDTH){c[CORR_WIDTH-1]}}, c};
        assign cand_lo  = {m_lo[METRIC_WIDTH-1], m_lo} + corr_ext;
        assign cand_hi  = {m_hi[METRIC_WIDTH-1], m_hi} + corr_ext;

        // Strict compare: a tie keeps the lower-index predecessor.
        assign dec[s]   = cand_hi > cand_lo;
        assign sel[s]   = dec[s] ? cand_hi : cand_lo;
        assign diff     = sel[s] - max_val;
        assign metric_new[s] = (diff < SAT_MIN) ? SAT_MIN[METRIC_WIDTH-1:0]
                                                : diff[METRIC_WIDTH-1:0];
    end

    always_comb begin
        max_val = sel[0];
        if (sel[1] > max_val) max_val = sel[1];
        if (sel[2] > max_val) max_val = sel[2];
        if (sel[3] > max_val) max_val = sel[3];
    end

    // Descending scan so the lowest index holding the maximum wins.
    always_comb begin
        best = 2'd3;
        if (sel[2] == max_val) best = 2'd2;
        if (sel[1] == max_val) best = 2'd1;
        if (sel[0] == max_val) best = 2'd0;
    end

endmodule

// File: rtl/fm0_viterbi_stream_decoder.sv
// Streaming FM0 Viterbi decoder: metric registers, register-exchange survivors,
// symbol counter, IDLE/RUN/FLUSH control and registered bit output.
module fm0_viterbi_stream_decoder
    import fm0_viterbi_pkg::*;
#(
    parameter int CORR_WIDTH      = 8,
    parameter int TRACEBACK_DEPTH = 16,
    parameter int METRIC_WIDTH    = CORR_WIDTH + 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*CORR_WIDTH-1:0] corr_dat,
    input  logic                    corr_vld,
    input  logic                    corr_sof,
    input  logic                    corr_last,
    output logic                    corr_rdy,
    output logic                    out_dat,
    output logic                    out_vld,
    output logic                    out_last
);

    localparam int D  = TRACEBACK_DEPTH;
    localparam int KW = $clog2(D + 1);
    localparam logic [KW-1:0] K_MAX     = KW'(D);
    localparam logic [KW-1:0] FLUSH_MAX = KW'(D - 1);

    fsm_state_t state;
    fsm_state_t state_next;

    logic [3:0][METRIC_WIDTH-1:0] metric;
    logic [3:0][METRIC_WIDTH-1:0] acs_in;
    logic [3:0][METRIC_WIDTH-1:0] metric_new;
    logic [3:0][D-1:0]            path;
    logic [3:0][D-1:0]            path_new;
    logic [3:0]                   dec;
    logic [1:0]                   best;
    logic [KW-1:0]                k;
    logic [KW-1:0]                k_new;
    logic [KW-1:0]                flush_len;
    logic [KW-1:0]                flush_cnt;
    logic [D-1:0]                 flush_path;
    logic                         accept;
    logic                         take;
    logic                         emit_vld;
    logic                         emit_dat;
    logic                         emit_last;

    assign accept = corr_vld && corr_rdy;
    assign take   = accept && (corr_sof || state == RUN);

    // A start-of-frame symbol decodes from a clean slate of zero metrics.
    assign acs_in    = corr_sof ? '0 : metric;
    assign k_new     = corr_sof ? KW'(1) : ((k == K_MAX) ? K_MAX : k + 1'b1);
    assign flush_len = (k_new == K_MAX) ? FLUSH_MAX : k_new;

    fm0_acs_norm #(
        .CORR_WIDTH   (CORR_WIDTH),
        .METRIC_WIDTH (METRIC_WIDTH)
    ) u_acs (
        .corr       (corr_dat),
        .metric     (acs_in),
        .metric_new (metric_new),
        .dec        (dec),
        .best       (best)
    );

    for (genvar s = 0; s < 4; s++) begin : g_surv
        logic [1:0] pred;
        assign pred        = dec[s] ? PRED_HI[s] : PRED_LO[s];
        assign path_new[s] = {path[pred][D-2:0], STATE_BIT[s]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && corr_sof) state_next = corr_last ? FLUSH : RUN;
            RUN:     if (accept && corr_last) state_next = FLUSH;
            FLUSH:   if (flush_cnt == KW'(1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The oldest survivor bit leaves once the window is full; the flush
    // register is pre-aligned so its MSB is always the next bit to emit.
    always_comb begin
        corr_rdy  = (state != FLUSH);
        emit_vld  = 1'b0;
        emit_dat  = 1'b0;
        emit_last = 1'b0;
        case (state)
            IDLE, RUN: begin
                if (take && k_new == K_MAX) begin
                    emit_vld = 1'b1;
                    emit_dat = path_new[best][D-1];
                end
            end
            FLUSH: begin
                emit_vld  = 1'b1;
                emit_dat  = flush_path[D-1];
                emit_last = (flush_cnt == KW'(1));
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            metric     <= '0;
            path       <= '0;
            k          <= '0;
            flush_path <= '0;
            flush_cnt  <= '0;
            out_dat    <= 1'b0;
            out_vld    <= 1'b0;
            out_last   <= 1'b0;
        end else begin
            out_vld  <= emit_vld;
            out_dat  <= emit_dat;
            out_last <= emit_last;
            if (take) begin
                metric <= metric_new;
                path   <= path_new;
                k      <= k_new;
                if (corr_last) begin
                    flush_path <= path_new[best] << (K_MAX - flush_len);
                    flush_cnt  <= flush_len;
                end
            end else if (state == FLUSH) begin
                flush_path <= flush_path << 1;
                flush_cnt  <= flush_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fm0_viterbi_stream_decoder.sv
// Directed bench for the FM0 Viterbi decoder: an FM0 encoder model feeds
// soft correlations and a scoreboard queue holds the transmitted bits.
module tb_fm0_viterbi_stream_decoder;

    localparam int CW = 8;
    localparam int D  = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [4*CW-1:0] corr_dat;
    logic          corr_vld;
    logic          corr_sof;
    logic          corr_last;
    logic          corr_rdy;
    logic          out_dat;
    logic          out_vld;
    logic          out_last;

    typedef struct packed {
        logic dat;
        logic last;
    } exp_t;

    exp_t exp_q[$];
    bit   frame_bits[$];
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;

    fm0_viterbi_stream_decoder #(
        .CORR_WIDTH      (CW),
        .TRACEBACK_DEPTH (D),
        .METRIC_WIDTH    (CW + 3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .corr_dat  (corr_dat),
        .corr_vld  (corr_vld),
        .corr_sof  (corr_sof),
        .corr_last (corr_last),
        .corr_rdy  (corr_rdy),
        .out_dat   (out_dat),
        .out_vld   (out_vld),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Symbol whose first half is at level start_pos carrying data bit b.
    function automatic logic [1:0] fm0_symbol(input logic start_pos, input logic b);
        if (b) return start_pos ? 2'd0 : 2'd3;
        return start_pos ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [4*CW-1:0] corr_vec(input logic [1:0] a, input int va,
                                                 input logic [1:0] b, input int vb,
                                                 input int vrest);
        logic [4*CW-1:0] v;
        for (int s = 0; s < 4; s++) begin
            if (2'(s) == b)      v[s*CW +: CW] = CW'(vb);
            else if (2'(s) == a) v[s*CW +: CW] = CW'(va);
            else                 v[s*CW +: CW] = CW'(vrest);
        end
        return v;
    endfunction

    task automatic load_bits(input logic [31:0] pat, input int n);
        frame_bits.delete();
        for (int i = n - 1; i >= 0; i--) frame_bits.push_back(pat[i]);
    endtask

    task automatic load_random(input int n);
        frame_bits.delete();
        for (int i = 0; i < n; i++) frame_bits.push_back(bit'($urandom_range(0, 1)));
    endtask

    task automatic apply_stimulus(input logic [4*CW-1:0] dat, input logic sof, input logic last);
        int guard = 0;
        while (corr_rdy !== 1'b1 && guard < 4 * D) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard == 4 * D) check_output("rdy_wait_timeout", corr_rdy, 1);
        corr_dat  = dat;
        corr_vld  = 1'b1;
        corr_sof  = sof;
        corr_last = last;
        @(posedge clk); #1;
        corr_vld  = 1'b0;
        corr_sof  = 1'b0;
        corr_last = 1'b0;
    endtask

    // complete=0 sends an open frame with no last; rst_flush hits reset mid-flush.
    task automatic send_frame(input int n, input int bad_idx, input int amp,
                              input bit complete, input bit rst_flush);
        logic prev_end = 1'b0;
        logic start;
        logic [1:0] tx;
        logic [4*CW-1:0] v;
        int k;
        int low;
        int m;
        for (int i = 0; i < n; i++) begin
            start = ~prev_end;
            tx    = fm0_symbol(start, frame_bits[i]);
            if (i == bad_idx) v = corr_vec(tx, 50, fm0_symbol(prev_end, frame_bits[i]), 100, -100);
            else              v = corr_vec(tx, amp, tx, amp, -amp);
            prev_end = frame_bits[i] ? start : ~start;
            if (complete) exp_q.push_back('{dat: frame_bits[i], last: (i == n - 1)});
            apply_stimulus(v, i == 0, complete && (i == n - 1));
            k = (i + 1 > D) ? D : i + 1;
            check_output("stream_vld", out_vld, (k >= D) ? 1 : 0);
        end
        if (!complete) return;
        if (rst_flush) begin
            @(posedge clk); #2;
            rst = 1'b1;
            #1;
            check_output("async_rst_rdy", corr_rdy, 1);
            check_output("async_rst_vld", out_vld, 0);
            check_output("async_rst_last", out_last, 0);
            exp_q.delete();
            repeat (2) @(negedge clk);
            rst = 1'b0;
            return;
        end
        m   = (n >= D) ? D - 1 : n;
        low = 0;
        while (corr_rdy === 1'b0 && low < 4 * D) begin
            low++;
            @(posedge clk); #1;
        end
        check_output("rdy_low_cycles", low, m);
        @(negedge clk); #1;
        check_output("queue_drained", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && out_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_output("spurious_vld", out_vld, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_output("out_dat", out_dat, e.dat);
                check_output("out_last", out_last, e.last);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        corr_dat  = '0;
        corr_vld  = 1'b0;
        corr_sof  = 1'b0;
        corr_last = 1'b0;
        #12;
        check_output("reset_rdy", corr_rdy, 1);
        check_output("reset_vld", out_vld, 0);
        check_output("reset_last", out_last, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        load_bits(32'b1011001, 7);
        send_frame(7, -1, 100, 1'b1, 1'b0);

        load_bits(32'b011, 3);
        send_frame(3, -1, 100, 1'b1, 1'b0);

        load_bits(32'hB3A5C, 20);
        send_frame(20, 9, 100, 1'b1, 1'b0);

        load_bits(32'b110, 3);
        send_frame(3, -1, 100, 1'b0, 1'b0);
        load_bits(32'b100101, 6);
        send_frame(6, -1, 100, 1'b1, 1'b0);

        load_bits(32'b0110100, 7);
        send_frame(7, -1, 100, 1'b1, 1'b1);
        load_random(12);
        send_frame(12, -1, 100, 1'b1, 1'b0);

        load_bits(32'b1, 1);
        send_frame(1, -1, 100, 1'b1, 1'b0);

        load_random(10000);
        send_frame(10000, -1, 127, 1'b1, 1'b0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
